// File: rtl/sodor_dmem_responder.sv
// sodor_dmem_responder
// Responder end of the Sodor dmem request/response interface. One load or
// store is accepted per cycle against a word-addressed array, and each
// accepted request produces exactly one in-order response LATENCY cycles
// later through a fixed shift-register pipeline.
//
// Optional feature macro: DMEM_RESP_STALL_EN
//   When defined, a 16-bit LFSR injects pseudo-random backpressure on
//   req_ready, bounded to at most 3 consecutive stall cycles.
//
// LATENCY legal range is 1..4.
// Array contents are intentionally not reset; only control state is.

module sodor_dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_fcn,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  accept;
    logic                  do_write;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     stage0_data;

    logic [LATENCY-1:0]    pipe_valid;
    logic [LATENCY-1:0]    pipe_err;
    logic [DATA_W-1:0]     pipe_data [LATENCY];

    // Upper address bits alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[DATA_W-1:DEPTH_LOG2+2];

    assign word_idx    = req_addr[DEPTH_LOG2+1:2];
    assign misaligned  = (req_addr[1:0] != 2'b00);
    assign accept      = req_valid && req_ready;
    assign do_write    = accept && req_fcn && !misaligned;
    assign rd_data     = mem[word_idx];
    assign stage0_data = (accept && !req_fcn && !misaligned) ? rd_data : '0;

`ifdef DMEM_RESP_STALL_EN
    logic [15:0] lfsr;
    logic [1:0]  stall_cnt;
    logic        lfsr_stall;
    logic        force_ready;
    logic        lfsr_fb;

    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_stall  = (lfsr[1:0] == 2'b00);
    assign force_ready = (stall_cnt == 2'd3);
    assign req_ready   = !rst && (!lfsr_stall || force_ready);

    // LFSR advances every cycle; stall counter bounds consecutive stalls to 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= 16'hACE1;
            stall_cnt <= 2'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (force_ready) begin
                stall_cnt <= 2'd0;
            end else if (lfsr_stall) begin
                stall_cnt <= stall_cnt + 2'd1;
            end else begin
                stall_cnt <= 2'd0;
            end
        end
    end
`else
    // Ready whenever not in reset; deasserting in the reset cycle itself
    // keeps anything presented during reset from being accepted.
    assign req_ready = !rst;
`endif

    // Single-port array write on the accept edge; no reset on contents.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= req_data;
        end
    end

    // Response pipeline: shifts every cycle, reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && misaligned;
            pipe_data[0]  <= stage0_data;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign resp_valid = pipe_valid[LATENCY-1];
    assign resp_err   = pipe_err[LATENCY-1];
    assign resp_data  = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_sodor_dmem_responder.sv
// Directed testbench for sodor_dmem_responder (default parameters, LATENCY=2).
// A negedge monitor queues every response with the cycle it was seen in;
// scenario tasks pop and compare against hand-computed expectations.

module tb_sodor_dmem_responder;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              req_fcn = 1'b0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_count = 0;

    logic [31:0] rq_data [$];
    logic        rq_err  [$];
    int          rq_cyc  [$];

    sodor_dmem_responder #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_fcn   (req_fcn),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            rq_data.push_back(resp_data);
            rq_err.push_back(resp_err);
            rq_cyc.push_back(cyc);
            resp_count <= resp_count + 1;
        end
    end

    // Present a request from posedge+1 and hold it until accepted; returns
    // the cycle number of the accepting edge.
    task automatic drive(input logic fcn, input logic [31:0] addr,
                         input logic [31:0] data, output int acc);
        bit rdy;
        int tries;
        tries     = 0;
        acc       = -1;
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_addr  = addr;
        req_data  = data;
        do begin
            @(negedge clk);
            rdy = (req_ready === 1'b1);
            @(posedge clk);
            #1;
            tries++;
        end while (!rdy && tries < 20);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL accept_timeout: addr %h not accepted after %0d cycles", addr, tries);
        end else begin
            acc = cyc;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit got, output logic [31:0] d,
                             output logic e, output int c);
        got = 1'b0;
        d   = '0;
        e   = 1'b0;
        c   = 0;
        for (int k = 0; k < 12; k++) begin
            if (rq_data.size() > 0) begin
                got = 1'b1;
                d   = rq_data.pop_front();
                e   = rq_err.pop_front();
                c   = rq_cyc.pop_front();
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_ready: got %b expected 0", req_ready);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_outputs: got v=%b d=%h e=%b expected v=0 d=0 e=0",
                     resp_valid, resp_data, resp_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int aw, ar, c;
        bit got;
        logic [31:0] d;
        logic e;
        drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, aw);
        drive(1'b0, 32'h0000_0100, 32'h0, ar);
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: got valid=%b d=%h e=%b expected valid=1 d=00000000 e=0", got, d, e);
        end
        checks++;
        if (c !== aw + LATENCY - 1) begin
            errors++;
            $display("FAIL wr_latency: got cycle %0d expected %0d", c, aw + LATENCY - 1);
        end
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: got valid=%b d=%h e=%b expected valid=1 d=deadbeef e=0", got, d, e);
        end
        checks++;
        if (c !== ar + LATENCY - 1) begin
            errors++;
            $display("FAIL rd_latency: got cycle %0d expected %0d", c, ar + LATENCY - 1);
        end
    endtask

    task automatic test_alias();
        int aw, ar, c;
        bit got;
        logic [31:0] d;
        logic e;
        drive(1'b1, 32'h0000_0004, 32'h1234_5678, aw);
        drive(1'b0, 32'h0000_1004, 32'h0, ar);
        wait_resp(got, d, e, c);
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'h1234_5678 || e !== 1'b0) begin
            errors++;
            $display("FAIL alias_read: got valid=%b d=%h e=%b expected valid=1 d=12345678 e=0", got, d, e);
        end
    endtask

    task automatic test_misaligned();
        int aw, ar, am, c;
        bit got;
        logic [31:0] d;
        logic e;
        drive(1'b1, 32'h0000_0102, 32'hFFFF_FFFF, aw);
        drive(1'b0, 32'h0000_0100, 32'h0, ar);
        drive(1'b0, 32'h0000_0101, 32'h0, am);
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_write: got valid=%b d=%h e=%b expected valid=1 d=00000000 e=1", got, d, e);
        end
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_nowrite: got valid=%b d=%h e=%b expected valid=1 d=deadbeef e=0", got, d, e);
        end
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_read: got valid=%b d=%h e=%b expected valid=1 d=00000000 e=1", got, d, e);
        end
        checks++;
        if (c !== am + LATENCY - 1) begin
            errors++;
            $display("FAIL misaligned_latency: got cycle %0d expected %0d", c, am + LATENCY - 1);
        end
    endtask

    task automatic test_back_to_back();
        int acc [8];
        logic [31:0] exp_d [8];
        int c;
        bit got;
        logic [31:0] d;
        logic e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), acc[i]);
            exp_d[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h40 + 32'(i * 4), 32'h0, acc[i+4]);
            exp_d[i+4] = 32'hA5A5_0000 + 32'(i);
        end
        for (int i = 0; i < 8; i++) begin
            wait_resp(got, d, e, c);
            checks++;
            if (!got || d !== exp_d[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got valid=%b d=%h e=%b expected valid=1 d=%h e=0",
                         i, got, d, e, exp_d[i]);
            end
            checks++;
            if (c !== acc[i] + LATENCY - 1) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got cycle %0d expected %0d", i, c, acc[i] + LATENCY - 1);
            end
        end
    endtask

    task automatic test_midflight_reset();
        int acc [3];
        int a, c, base, expect_cnt, rst_edge;
        bit got;
        logic [31:0] d;
        logic e;
        drive(1'b1, 32'h0000_0200, 32'h1111_1111, a);
        wait_resp(got, d, e, c);
        base = resp_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0000_0100, 32'h0, acc[i]);
        end
        // A write presented during reset must not land.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_fcn   = 1'b1;
        req_addr  = 32'h0000_0200;
        req_data  = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: got %b expected 0", req_ready);
        end
        @(posedge clk);
        #1;
        rst_edge  = cyc;
        rst       = 1'b0;
        req_valid = 1'b0;
        expect_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (acc[i] + LATENCY - 1 < rst_edge) expect_cnt++;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (resp_count - base !== expect_cnt) begin
            errors++;
            $display("FAIL midreset_drop: got %0d responses expected %0d", resp_count - base, expect_cnt);
        end
        rq_data.delete();
        rq_err.delete();
        rq_cyc.delete();
        drive(1'b0, 32'h0000_0200, 32'h0, a);
        wait_resp(got, d, e, c);
        checks++;
        if (!got || d !== 32'h1111_1111 || e !== 1'b0) begin
            errors++;
            $display("FAIL midreset_read: got valid=%b d=%h e=%b expected valid=1 d=11111111 e=0", got, d, e);
        end
        checks++;
        if (c !== a + LATENCY - 1) begin
            errors++;
            $display("FAIL midreset_latency: got cycle %0d expected %0d", c, a + LATENCY - 1);
        end
    endtask

    task automatic test_stream();
        logic [31:0] mdl [16];
        logic [31:0] exp_q [$];
        int i, zeros, maxz, idx, n;
        bit rdy;
        logic [31:0] d;
        logic e;
        i     = 0;
        zeros = 0;
        maxz  = 0;
        rq_data.delete();
        rq_err.delete();
        rq_cyc.delete();
        req_valid = 1'b1;
        repeat (1000) begin
            idx      = (i / 2) % 16;
            req_fcn  = (i % 2 == 0);
            req_addr = 32'h400 + 32'(idx * 4);
            req_data = 32'(i);
            @(negedge clk);
            rdy = (req_ready === 1'b1);
            if (!rdy) zeros++;
            else zeros = 0;
            if (zeros > maxz) maxz = zeros;
            @(posedge clk);
            #1;
            if (rdy) begin
                if (req_fcn) begin
                    mdl[idx] = 32'(i);
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(mdl[idx]);
                end
                i++;
            end
        end
        req_valid = 1'b0;
        repeat (LATENCY + 4) begin
            @(posedge clk);
            #1;
        end
`ifdef DMEM_RESP_STALL_EN
        checks++;
        if (maxz > 3) begin
            errors++;
            $display("FAIL stream_max_stall: got %0d consecutive stalls expected at most 3", maxz);
        end
`else
        checks++;
        if (maxz != 0) begin
            errors++;
            $display("FAIL stream_ready: got %0d stall cycles expected 0", maxz);
        end
`endif
        checks++;
        if (rq_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stream_count: got %0d responses expected %0d", rq_data.size(), exp_q.size());
        end
        n = (rq_data.size() < exp_q.size()) ? rq_data.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            d = rq_data.pop_front();
            e = rq_err.pop_front();
            checks++;
            if (d !== exp_q[k] || e !== 1'b0) begin
                errors++;
                $display("FAIL stream_order[%0d]: got d=%h e=%b expected d=%h e=0", k, d, e, exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_misaligned();
        test_back_to_back();
        test_midflight_reset();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sodor_dmem_responder.md
# sodor_dmem_responder

Responder end of the Sodor data-memory request/response interface. Accepts one load/store request per cycle from the core, performs it against an internal word-addressed array, and returns exactly one in-order response per accepted request after a fixed pipeline latency. It replaces a zero-wait memory on the dmem side of the top level so that the core's multi-cycle memory paths are exercised. Optional LFSR-driven backpressure supports fuzzing.

## Interface
- `DATA_W`, default 32: bus width for address and data (matches `SIZE_OF_THE_BUS`).
- `DEPTH_LOG2`, default 10: log2 of the array depth in words.
- `LATENCY`, default 2: cycles from acceptance to response. Legal range is 1..4.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept this cycle.
- `req_addr` in DATA_W: byte address.
- `req_data` in DATA_W: store data.
- `req_fcn` in 1: 1 = write, 0 = read.
- `resp_valid` out 1: response present. This is a single-cycle pulse and is never back-pressured.
- `resp_data` out DATA_W: read data. It is 0 for writes and for errors.
- `resp_err` out 1: the response belongs to a misaligned request.

## Operation
- A request is accepted when `req_valid && req_ready`.
- Word index is `req_addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes.
- Misaligned request (`req_addr[1:0] != 0`):
  - No array access and no write.
  - The response carries `resp_err=1` and `resp_data=0`.
- Aligned write:
  - The array word is updated on the accept edge.
  - The response carries `resp_data=0` and `resp_err=0`.
- Aligned read:
  - The array word is sampled on the accept cycle.
  - A read accepted the cycle after a write to the same word returns the new data.
  - Read and write are never accepted in the same cycle, since there is one port.
- Response pipeline:
  - A `LATENCY`-stage shift register carries {valid, data, err} and advances every cycle unconditionally.
  - Stage `LATENCY-1` drives the outputs.
  - Responses leave strictly in acceptance order, with no reordering or merging.
- Array contents are not reset. Simulation init is outside this block.
- With `DMEM_RESP_STALL_EN` undefined, `req_ready` is 1 in every cycle except the reset cycle.

## Timing
- Reset:
  - Applies on any `posedge clk` with `rst=1`.
  - Clears every pipeline valid bit, `resp_valid=0`, `resp_data=0`, `resp_err=0`, `req_ready=0`.
  - `req_ready` rises in the first cycle after `rst` falls.
- Reset mid-operation:
  - All in-flight responses are dropped with no resp pulse.
  - Writes already accepted remain in the array.
- Latency: a request accepted on edge N produces `resp_valid=1` during the cycle after edge N+LATENCY-1. With LATENCY=1, the response appears in the cycle immediately following acceptance.
- Throughput is one request per cycle. Back-to-back accepts give back-to-back `resp_valid`.
- `req_valid` asserted while `req_ready=0`: nothing is accepted. The initiator must hold the request stable until accepted.

## Configuration
- `DMEM_RESP_STALL_EN` defined: adds pseudo-random backpressure.
  - Stall source is a 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle.
  - `req_ready=0` when `lfsr[1:0]==2'b00`.
  - A saturating stall counter forces `req_ready=1` after 3 consecutive stall cycles, then clears.
  - The response pipeline is unaffected by stalls.
- `DMEM_RESP_STALL_EN` undefined: there is no LFSR or counter, and `req_ready` follows the rule in Operation.

## Test plan
- Reset release:
  - Assert `rst` for 2 cycles, then deassert.
  - Required: `resp_valid=0` throughout, `req_ready=0` during reset, `req_ready=1` on the first cycle after (stall build: per LFSR seed).
- Write then read (LATENCY=2):
  - Write 0xDEADBEEF to 0x100, then read 0x100 on the next cycle.
  - Required: write response with data 0 at +2 cycles, read response with data 0xDEADBEEF one cycle later.
- Aliasing:
  - Write 0x12345678 to 0x0000_0004, then read 0x0000_1004 (DEPTH_LOG2=10).
  - Required: read returns 0x12345678.
- Misaligned:
  - Write 0xFFFFFFFF to 0x102, then read 0x100 (previously 0xDEADBEEF).
  - Required: first response has `resp_err=1` and data 0; read returns 0xDEADBEEF unchanged.
- Mid-flight reset:
  - Issue reads on 3 consecutive cycles, then pulse `rst` for one cycle before any response.
  - Required: zero `resp_valid` pulses for those reads; the next read after reset returns correct data at LATENCY.
- Stall build:
  - Drive `req_valid=1` continuously for 1000 cycles.
  - Required: never more than 3 consecutive `req_ready=0`; `resp_valid` count equals accept count; order is preserved.
